// File: rtl/mkii_pkg.sv
// mkii_pkg: shared types and constants for the MkII fetch front-end.
package mkii_pkg;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic {RUN, FLUSH} fetch_state_t;
endpackage

// File: rtl/mkii_fetch_fifo.sv
// mkii_fetch_fifo: prefetch queue of {pc, instr} words with push, pop and clear.
module mkii_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [W-1:0]             wdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic [W-1:0]             head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   count_q;
    logic          pop_ok;
    assign pop_ok = pop & ~empty;
    assign empty  = count_q == '0;
    assign count  = count_q;
    assign head   = mem_q[rd_q];
    // clear wins over a same-cycle push so a redirect drops the landing response
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop_ok);
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear && !reset) mem_q[wr_q] <= wdata;
    end
endmodule

// File: rtl/mkii_fetch_unit.sv
// mkii_fetch_unit: PC, imem issue logic, redirect FSM and prefetch queue.
module mkii_fetch_unit
    import mkii_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] machine_code,
    output logic [ADDR_W-1:0]  code_pc,
    output logic               code_valid,
    input  logic               code_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);
    localparam int W = ADDR_W + INSTR_W;
    fetch_state_t          state_q;
    logic [ADDR_W-1:0]     pc_q, pc_d, rsp_pc_q;
    logic                  inflight_q, kill_q;
    logic                  pop, push, empty;
    logic [$clog2(DEPTH):0] count;
    logic [W-1:0]          head;
    assign pop        = code_valid & code_ready;
    // slots already promised (queued + in flight) minus the one leaving now
    assign imem_req   = !reset && !redirect && (int'(count) + int'(inflight_q) - int'(pop) < DEPTH);
    assign imem_addr  = pc_q;
    assign push       = inflight_q & ~kill_q & (state_q == RUN);
    assign code_valid = ~empty;
    assign machine_code = empty ? NOP_INSTR : head[INSTR_W-1:0];
    assign code_pc    = empty ? RESET_PC : head[W-1:INSTR_W];
    assign pc_d = redirect ? redirect_pc : imem_req ? pc_q + ADDR_W'(1) : pc_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= redirect ? FLUSH : RUN;
            pc_q       <= pc_d;
            rsp_pc_q   <= imem_req ? pc_q : rsp_pc_q;
            inflight_q <= imem_req;
            kill_q     <= redirect;
        end
    end
    mkii_fetch_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .wdata ({rsp_pc_q, imem_rdata}),
        .count (count),
        .empty (empty),
        .head  (head)
    );
endmodule
